// File: rtl/systolic_pkg.sv
// Shared types and constants for the 2x2 systolic array controller.
// Covers state enums, feed/capture cycle indices and element slice positions.
package systolic_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } cst_e;

    typedef enum logic [1:0] {
        WIDLE,
        WLOAD0,
        WLOAD1
    } wst_e;

    localparam logic [2:0] K_R0_A0  = 3'd0;
    localparam logic [2:0] K_R0_A1  = 3'd1;
    localparam logic [2:0] K_R1_A0  = 3'd1;
    localparam logic [2:0] K_R1_A1  = 3'd2;
    localparam logic [2:0] K_CAP_C00 = 3'd2;
    localparam logic [2:0] K_CAP_C10 = 3'd3;
    localparam logic [2:0] K_CAP_C01 = 3'd3;
    localparam logic [2:0] K_CAP_C11 = 3'd4;
    localparam logic [2:0] K_EN_LAST = 3'd3;
    localparam logic [2:0] K_LAST    = 3'd4;

    localparam int E00 = 0;
    localparam int E01 = 1;
    localparam int E10 = 2;
    localparam int E11 = 3;

endpackage

// File: rtl/weight_bank_ctrl.sv
// B loader FSM and double-buffer bank bookkeeping.
// Loads go to the inactive bank; a swap request consumes a full shadow.
module weight_bank_ctrl
    import systolic_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          b_valid,
    input  logic [4*DW-1:0] b_data,
    input  logic          swap_req,
    output logic          b_ready,
    output logic          load_row0,
    output logic          load_row1,
    output logic          sel_w_active,
    output logic          sel_w_load,
    output logic          avail_d,
    output logic [DW-1:0] b00,
    output logic [DW-1:0] b01,
    output logic [DW-1:0] b10,
    output logic [DW-1:0] b11
);

    wst_e            wst_q, wst_d;
    logic [4*DW-1:0] b_q, b_d;
    logic            sf_q, sf_d;
    logic            av_q, av_d;
    logic            sel_q, sel_d;
    logic            sel_ld_q, sel_ld_d;
    logic            b_ready_q, b_ready_d;
    logic            ld0_q, ld0_d;
    logic            ld1_q, ld1_d;

    // Next-state for the loader, bank flags and registered controls.
    always_comb begin
        wst_d = wst_q;
        b_d   = b_q;
        sf_d  = sf_q;
        av_d  = av_q;
        sel_d = sel_q;
        unique case (wst_q)
            WIDLE: begin
                if (b_valid && b_ready_q) begin
                    b_d   = b_data;
                    wst_d = WLOAD0;
                end
            end
            WLOAD0: wst_d = WLOAD1;
            WLOAD1: begin
                wst_d = WIDLE;
                sf_d  = 1'b1;
            end
            default: wst_d = WIDLE;
        endcase
        if (swap_req && sf_q) begin
            sel_d = !sel_q;
            sf_d  = 1'b0;
            av_d  = 1'b1;
        end
        sel_ld_d  = !sel_d;
        b_ready_d = (wst_d == WIDLE) && !sf_d;
        ld0_d     = (wst_d == WLOAD0);
        ld1_d     = (wst_d == WLOAD1);
        avail_d   = av_d || sf_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wst_q     <= WIDLE;
            b_q       <= '0;
            sf_q      <= 1'b0;
            av_q      <= 1'b0;
            sel_q     <= 1'b0;
            sel_ld_q  <= 1'b1;
            b_ready_q <= 1'b0;
            ld0_q     <= 1'b0;
            ld1_q     <= 1'b0;
        end else begin
            wst_q     <= wst_d;
            b_q       <= b_d;
            sf_q      <= sf_d;
            av_q      <= av_d;
            sel_q     <= sel_d;
            sel_ld_q  <= sel_ld_d;
            b_ready_q <= b_ready_d;
            ld0_q     <= ld0_d;
            ld1_q     <= ld1_d;
        end
    end

    assign b_ready      = b_ready_q;
    assign load_row0    = ld0_q;
    assign load_row1    = ld1_q;
    assign sel_w_active = sel_q;
    assign sel_w_load   = sel_ld_q;
    assign b00 = b_q[E00*DW +: DW];
    assign b01 = b_q[E01*DW +: DW];
    assign b10 = b_q[E10*DW +: DW];
    assign b11 = b_q[E11*DW +: DW];

endmodule

// File: rtl/systolic_ctrl_2x2.sv
// Sequencer for the 2x2 weight-stationary array with double-buffered B.
// Feeds skewed A rows, enables MACs and returns bottom-row sums as C rows.
module systolic_ctrl_2x2
    import systolic_pkg::*;
#(
    parameter int DW = 4,
    parameter int CW = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4*DW-1:0] b_data,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4*DW-1:0] a_data,
    output logic            res_valid,
    output logic            res_row,
    output logic [CW-1:0]   res_c0,
    output logic [CW-1:0]   res_c1,
    output logic [DW-1:0]   arr_a_row0,
    output logic [DW-1:0]   arr_a_row1,
    output logic [DW-1:0]   arr_b00,
    output logic [DW-1:0]   arr_b01,
    output logic [DW-1:0]   arr_b10,
    output logic [DW-1:0]   arr_b11,
    output logic            arr_load_row0,
    output logic            arr_load_row1,
    output logic            arr_sel_w_load,
    output logic            arr_sel_w_active,
    output logic            arr_clear_psum,
    output logic            arr_compute_en,
    input  logic [CW-1:0]   arr_c10,
    input  logic [CW-1:0]   arr_c11
);

    cst_e            cst_q, cst_d;
    logic [2:0]      k_q, k_d;
    logic [4*DW-1:0] a_q, a_d;
    logic [CW-1:0]   c00_q, c00_d;
    logic [CW-1:0]   c10_q, c10_d;
    logic            rv_q, rv_d;
    logic            rr_q, rr_d;
    logic [CW-1:0]   r0_q, r0_d;
    logic [CW-1:0]   r1_q, r1_d;
    logic [DW-1:0]   ar0_q, ar0_d;
    logic [DW-1:0]   ar1_q, ar1_d;
    logic            clr_q, clr_d;
    logic            en_q, en_d;
    logic            ard_q, ard_d;
    logic            run_d;
    logic            a_fire;
    logic            avail_d;

    assign a_fire = a_valid && ard_q;

    weight_bank_ctrl #(.DW(DW)) u_wbank (
        .clk          (clk),
        .rst_n        (rst_n),
        .b_valid      (b_valid),
        .b_data       (b_data),
        .swap_req     (a_fire),
        .b_ready      (b_ready),
        .load_row0    (arr_load_row0),
        .load_row1    (arr_load_row1),
        .sel_w_active (arr_sel_w_active),
        .sel_w_load   (arr_sel_w_load),
        .avail_d      (avail_d),
        .b00          (arr_b00),
        .b01          (arr_b01),
        .b10          (arr_b10),
        .b11          (arr_b11)
    );

    // Compute FSM, partial-sum capture and result row formation.
    always_comb begin
        cst_d = cst_q;
        k_d   = k_q;
        a_d   = a_q;
        c00_d = c00_q;
        c10_d = c10_q;
        rv_d  = 1'b0;
        rr_d  = 1'b0;
        r0_d  = '0;
        r1_d  = '0;
        unique case (cst_q)
            IDLE: begin
                if (a_fire) begin
                    cst_d = RUN;
                    k_d   = 3'd0;
                    a_d   = a_data;
                end
            end
            RUN: begin
                if (k_q == K_LAST) begin
                    cst_d = IDLE;
                    k_d   = 3'd0;
                end else begin
                    k_d = k_q + 3'd1;
                end
                if (k_q == K_CAP_C00) c00_d = arr_c10;
                if (k_q == K_CAP_C10) c10_d = arr_c10;
                if (k_q == K_CAP_C01) begin
                    rv_d = 1'b1;
                    rr_d = 1'b0;
                    r0_d = c00_q;
                    r1_d = arr_c11;
                end
                if (k_q == K_CAP_C11) begin
                    rv_d = 1'b1;
                    rr_d = 1'b1;
                    r0_d = c10_q;
                    r1_d = arr_c11;
                end
            end
        endcase
    end

    // Array feed and handshake controls derived from the next state.
    always_comb begin
        run_d = (cst_d == RUN);
        ar0_d = '0;
        ar1_d = '0;
        if (run_d) begin
            if (k_d == K_R0_A0) ar0_d = a_d[E00*DW +: DW];
            if (k_d == K_R0_A1) ar0_d = a_d[E10*DW +: DW];
            if (k_d == K_R1_A0) ar1_d = a_d[E01*DW +: DW];
            if (k_d == K_R1_A1) ar1_d = a_d[E11*DW +: DW];
        end
        clr_d = !run_d;
        en_d  = run_d && (k_d <= K_EN_LAST);
        ard_d = !run_d && avail_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cst_q <= IDLE;
            k_q   <= 3'd0;
            a_q   <= '0;
            c00_q <= '0;
            c10_q <= '0;
            rv_q  <= 1'b0;
            rr_q  <= 1'b0;
            r0_q  <= '0;
            r1_q  <= '0;
            ar0_q <= '0;
            ar1_q <= '0;
            clr_q <= 1'b1;
            en_q  <= 1'b0;
            ard_q <= 1'b0;
        end else begin
            cst_q <= cst_d;
            k_q   <= k_d;
            a_q   <= a_d;
            c00_q <= c00_d;
            c10_q <= c10_d;
            rv_q  <= rv_d;
            rr_q  <= rr_d;
            r0_q  <= r0_d;
            r1_q  <= r1_d;
            ar0_q <= ar0_d;
            ar1_q <= ar1_d;
            clr_q <= clr_d;
            en_q  <= en_d;
            ard_q <= ard_d;
        end
    end

    assign a_ready        = ard_q;
    assign res_valid      = rv_q;
    assign res_row        = rr_q;
    assign res_c0         = r0_q;
    assign res_c1         = r1_q;
    assign arr_a_row0     = ar0_q;
    assign arr_a_row1     = ar1_q;
    assign arr_clear_psum = clr_q;
    assign arr_compute_en = en_q;

endmodule

// File: tb/tb_systolic_ctrl_2x2.sv
// Bench for systolic_ctrl_2x2 with a behavioural 2x2 array model.
// Expected C rows are queued at each A handshake and compared on output.
module tb_systolic_ctrl_2x2;

    localparam int DW = 4;
    localparam int CW = 9;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            b_valid = 1'b0;
    logic            b_ready;
    logic [4*DW-1:0] b_data = '0;
    logic            a_valid = 1'b0;
    logic            a_ready;
    logic [4*DW-1:0] a_data = '0;
    logic            res_valid;
    logic            res_row;
    logic [CW-1:0]   res_c0;
    logic [CW-1:0]   res_c1;
    logic [DW-1:0]   arr_a_row0;
    logic [DW-1:0]   arr_a_row1;
    logic [DW-1:0]   arr_b00;
    logic [DW-1:0]   arr_b01;
    logic [DW-1:0]   arr_b10;
    logic [DW-1:0]   arr_b11;
    logic            arr_load_row0;
    logic            arr_load_row1;
    logic            arr_sel_w_load;
    logic            arr_sel_w_active;
    logic            arr_clear_psum;
    logic            arr_compute_en;
    logic [CW-1:0]   arr_c10;
    logic [CW-1:0]   arr_c11;

    always #5 clk = ~clk;

    systolic_ctrl_2x2 #(.DW(DW), .CW(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .b_valid          (b_valid),
        .b_ready          (b_ready),
        .b_data           (b_data),
        .a_valid          (a_valid),
        .a_ready          (a_ready),
        .a_data           (a_data),
        .res_valid        (res_valid),
        .res_row          (res_row),
        .res_c0           (res_c0),
        .res_c1           (res_c1),
        .arr_a_row0       (arr_a_row0),
        .arr_a_row1       (arr_a_row1),
        .arr_b00          (arr_b00),
        .arr_b01          (arr_b01),
        .arr_b10          (arr_b10),
        .arr_b11          (arr_b11),
        .arr_load_row0    (arr_load_row0),
        .arr_load_row1    (arr_load_row1),
        .arr_sel_w_load   (arr_sel_w_load),
        .arr_sel_w_active (arr_sel_w_active),
        .arr_clear_psum   (arr_clear_psum),
        .arr_compute_en   (arr_compute_en),
        .arr_c10          (arr_c10),
        .arr_c11          (arr_c11)
    );

    // Array model: two weight banks, a moves right, psum moves down.
    logic [DW-1:0] w [2][2][2];
    logic [DW-1:0] a00o, a10o;
    logic [CW-1:0] p00, p01, p10, p11;

    function automatic logic [CW-1:0] mul(input logic [DW-1:0] x, input logic [DW-1:0] y);
        return CW'(x) * CW'(y);
    endfunction

    always @(posedge clk) begin
        if (arr_load_row0) begin
            w[arr_sel_w_load][0][0] <= arr_b00;
            w[arr_sel_w_load][0][1] <= arr_b01;
        end
        if (arr_load_row1) begin
            w[arr_sel_w_load][1][0] <= arr_b10;
            w[arr_sel_w_load][1][1] <= arr_b11;
        end
        if (arr_clear_psum) begin
            p00 <= '0; p01 <= '0; p10 <= '0; p11 <= '0;
            a00o <= '0; a10o <= '0;
        end else if (arr_compute_en) begin
            p00  <= mul(arr_a_row0, w[arr_sel_w_active][0][0]);
            a00o <= arr_a_row0;
            p01  <= mul(a00o, w[arr_sel_w_active][0][1]);
            p10  <= p00 + mul(arr_a_row1, w[arr_sel_w_active][1][0]);
            a10o <= arr_a_row1;
            p11  <= p01 + mul(a10o, w[arr_sel_w_active][1][1]);
        end
    end

    assign arr_c10 = p10;
    assign arr_c11 = p11;

    typedef struct {
        int cyc;
        int row;
        int c0;
        int c1;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic            m_sf = 1'b0;
    logic            m_sel = 1'b0;
    logic [4*DW-1:0] m_sh = '0;
    logic [4*DW-1:0] m_act = '0;
    logic [4*DW-1:0] m_pend = '0;
    int              m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [15:0] pk(input logic [3:0] e00, input logic [3:0] e01,
                                       input logic [3:0] e10, input logic [3:0] e11);
        return {e11, e10, e01, e00};
    endfunction

    function automatic int el(input logic [15:0] m, input int i);
        return int'(m[i*4 +: 4]);
    endfunction

    function automatic void push_exp(input logic [15:0] a, input logic [15:0] b);
        int c00, c01, c10, c11;
        c00 = el(a, 0) * el(b, 0) + el(a, 1) * el(b, 2);
        c01 = el(a, 0) * el(b, 1) + el(a, 1) * el(b, 3);
        c10 = el(a, 2) * el(b, 0) + el(a, 3) * el(b, 2);
        c11 = el(a, 2) * el(b, 1) + el(a, 3) * el(b, 3);
        sb.push_back('{cyc + 5, 0, c00, c01});
        sb.push_back('{cyc + 6, 1, c10, c11});
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference bank tracking and scoreboard push on A handshake.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sf  <= 1'b0;
            m_sel <= 1'b0;
            m_cnt <= 0;
            sb.delete();
        end else begin
            if (a_valid && a_ready) begin
                push_exp(a_data, m_sf ? m_sh : m_act);
                if (m_sf) begin
                    m_act <= m_sh;
                    m_sel <= !m_sel;
                end
            end
            if (m_cnt == 1) begin
                m_sf <= 1'b1;
                m_sh <= m_pend;
            end else if (a_valid && a_ready && m_sf) begin
                m_sf <= 1'b0;
            end
            if (b_valid && b_ready) begin
                m_pend <= b_data;
                m_cnt  <= 2;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Result monitor.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (sb.size() == 0) begin
                chk("res_spurious", 32'(res_valid), 32'd0);
            end else begin
                chk("res_cyc", 32'(cyc), 32'(sb[0].cyc));
                chk("res_row", 32'(res_row), 32'(sb[0].row));
                chk("res_c0", 32'(res_c0), 32'(sb[0].c0));
                chk("res_c1", 32'(res_c1), 32'(sb[0].c1));
                void'(sb.pop_front());
            end
        end
    end

    task automatic send_b(input logic [15:0] d);
        b_valid = 1'b1;
        b_data  = d;
        for (int i = 0; i < 80 && !b_ready; i++) @(negedge clk);
        if (!b_ready) begin
            chk("b_ready_wait", 32'(b_ready), 32'd1);
            b_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            b_valid = 1'b0;
            chk("ld0_l1", 32'(arr_load_row0), 32'd1);
            chk("ld1_l1", 32'(arr_load_row1), 32'd0);
            chk("b_rdy_l1", 32'(b_ready), 32'd0);
            @(negedge clk);
            chk("ld0_l2", 32'(arr_load_row0), 32'd0);
            chk("ld1_l2", 32'(arr_load_row1), 32'd1);
            @(negedge clk);
            chk("ld1_l3", 32'(arr_load_row1), 32'd0);
            chk("b_rdy_l3", 32'(b_ready), 32'd0);
        end
    endtask

    task automatic send_a(input logic [15:0] d);
        a_valid = 1'b1;
        a_data  = d;
        for (int i = 0; i < 80 && !a_ready; i++) @(negedge clk);
        if (!a_ready) begin
            chk("a_ready_wait", 32'(a_ready), 32'd1);
            a_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            a_valid = 1'b0;
            chk("sel_act_h1", 32'(arr_sel_w_active), 32'(m_sel));
            chk("sel_ld_h1", 32'(arr_sel_w_load), 32'(!m_sel));
            chk("en_k0", 32'(arr_compute_en), 32'd1);
            chk("clr_k0", 32'(arr_clear_psum), 32'd0);
            chk("row0_k0", 32'(arr_a_row0), 32'(el(d, 0)));
            chk("a_rdy_k0", 32'(a_ready), 32'd0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_clear", 32'(arr_clear_psum), 32'd1);
        chk("rst_sel_ld", 32'(arr_sel_w_load), 32'd1);
        chk("rst_sel_act", 32'(arr_sel_w_active), 32'd0);
        chk("rst_en", 32'(arr_compute_en), 32'd0);
        chk("rst_res_v", 32'(res_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_a_ready", 32'(a_ready), 32'd0);
        chk("idle_b_ready", 32'(b_ready), 32'd1);
        chk("idle_clear", 32'(arr_clear_psum), 32'd1);
        chk("idle_row0", 32'(arr_a_row0), 32'd0);

        send_b(pk(1, 2, 3, 4));
        chk("a_rdy_l3", 32'(a_ready), 32'd1);
        send_a(pk(1, 1, 1, 1));
        drain();

        send_b(pk(1, 2, 3, 4));
        send_a(pk(2, 0, 0, 3));
        send_b(pk(1, 0, 0, 1));
        drain();
        send_a(pk(5, 6, 7, 8));
        drain();

        send_b(pk(15, 15, 15, 15));
        send_a(pk(15, 15, 15, 15));
        drain();

        a_valid = 1'b1;
        a_data  = pk(1, 1, 1, 1);
        b_valid = 1'b1;
        b_data  = pk(1, 2, 3, 4);
        chk("sim_a_rdy", 32'(a_ready), 32'd1);
        chk("sim_b_rdy", 32'(b_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("sim_sel", 32'(arr_sel_w_active), 32'(m_sel));
        chk("sim_ld0", 32'(arr_load_row0), 32'd1);
        drain();
        send_a(pk(2, 0, 0, 3));
        drain();

        send_a(pk(1, 1, 1, 1));
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_res_v", 32'(res_valid), 32'd0);
        chk("mid_en", 32'(arr_compute_en), 32'd0);
        chk("mid_clear", 32'(arr_clear_psum), 32'd1);
        chk("mid_sel_ld", 32'(arr_sel_w_load), 32'd1);
        chk("mid_sel_act", 32'(arr_sel_w_active), 32'd0);
        chk("mid_a_ready", 32'(a_ready), 32'd0);
        chk("mid_row1", 32'(arr_a_row1), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_res_v", 32'(res_valid), 32'd0);
            chk("post_a_ready", 32'(a_ready), 32'd0);
        end
        send_b(pk(1, 0, 0, 1));
        send_a(pk(5, 6, 7, 8));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl_2x2.md
# systolic_ctrl_2x2

Sequencing controller for the 2x2 weight-stationary systolic array with double-buffered B weights. Accepts B-matrix jobs and A-matrix jobs over valid/ready handshakes and loads B into the inactive weight bank while the active bank computes. It swaps banks between jobs, drives skewed A rows and MAC enables, and captures the bottom-row partial sums (`c10`/`c11`) as C rows. It sits directly between the job source and the array instance.

## Interface
- `DW`, 4: A/B element width.
- `CW`, 9: partial-sum and C element width; must hold 2·(2^DW−1)^2.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `b_valid` in 1, `b_ready` out 1, `b_data` in 4·DW: B job as {B11,B10,B01,B00}; B00 is in the LSBs.
- `a_valid` in 1, `a_ready` out 1, `a_data` in 4·DW: A job as {A11,A10,A01,A00}; A00 is in the LSBs.
- `res_valid` out 1, `res_row` out 1, `res_c0` out CW, `res_c1` out CW: C row result. There is no backpressure on results.
- `arr_a_row0`, `arr_a_row1` out DW: array A inputs.
- `arr_b00`, `arr_b01`, `arr_b10`, `arr_b11` out DW: array weight inputs.
- `arr_load_row0`, `arr_load_row1`, `arr_sel_w_load`, `arr_sel_w_active`, `arr_clear_psum`, `arr_compute_en` out 1: array controls.
- `arr_c10`, `arr_c11` in CW: bottom-row couts from the array.

## Operation
- All outputs are registered.
- Reset values:
  - `arr_clear_psum`=1 and `arr_sel_w_load`=1.
  - All other outputs are 0.
  - State is IDLE.
  - Internal flags: `active_valid`=0, `shadow_full`=0.
- Weight side: an independent loader FSM with states WIDLE, WLOAD0, WLOAD1.
  - `b_ready` = WIDLE & !`shadow_full`.
  - A B handshake latches `b_data` into the `arr_b*` registers and moves the FSM to WLOAD0.
  - In WLOAD0, `arr_load_row0`=1 for one cycle.
  - In WLOAD1, `arr_load_row1`=1 for one cycle.
  - Leaving WLOAD1 sets `shadow_full`=1 and returns to WIDLE.
  - `arr_sel_w_load` = !`arr_sel_w_active` at all times. It never changes mid-load, because a swap requires `shadow_full`.
- Compute side: an FSM with states IDLE and RUN, plus a cycle counter k = 0..4.
  - `a_ready` = IDLE & (`active_valid` | `shadow_full`).
  - In IDLE: `arr_clear_psum`=1 and `arr_compute_en`=0.
  - An A handshake in cycle H:
    - latches `a_data`;
    - if `shadow_full`, toggles `arr_sel_w_active`, clears `shadow_full` and sets `active_valid`;
    - enters RUN with k=0 in cycle H+1.
- In RUN: `arr_clear_psum`=0 and `arr_compute_en`=1 for k=0..3, 0 at k=4.
- A feed pattern in RUN (0 in all other cycles):
  - `arr_a_row0`: A00 at k0, A10 at k1.
  - `arr_a_row1`: A01 at k1, A11 at k2.
- Result capture:
  - `arr_c10` is sampled at k2 (C00) and k3 (C10).
  - `arr_c11` is sampled at k3 (C01) and k4 (C11).
- Result output:
  - Row 0 is presented at k4: `res_valid`=1, `res_row`=0, `res_c0`=C00, `res_c1`=C01.
  - Row 1 is presented at k4+1: `res_row`=1, `res_c0`=C10, `res_c1`=C11.
  - `res_valid` is high for exactly those 2 cycles.
- After k4 the compute FSM returns to IDLE.
- Arithmetic is unsigned. The controller only forwards values; CW is sized so no overflow occurs.

## Timing
- A handshake in cycle H:
  - weight swap is visible at H+1;
  - row 0 result at H+5, row 1 result at H+6;
  - `a_ready` goes high again at H+6 at the earliest.
- B handshake in cycle L: `arr_load_row0` at L+1, `arr_load_row1` at L+2, `shadow_full` at L+3, `b_ready` low from L+1.
- B loading overlaps RUN freely, because loads go to the inactive bank.
- B and A handshake in the same cycle: the A job uses the previously active (or already shadow_full) bank. The new B takes effect at the next A job.
- A second B job before any A job consumes the shadow: it stalls (`b_ready` low) until a swap.
- No A handshake before the first B load completes (`a_ready`=0).
- Reset mid-run or mid-load: all FSMs, flags and outputs return to their reset values asynchronously. Any partial job is discarded and no `res_valid` is issued.

## Structure
- Package `systolic_pkg` holds:
  - compute state enum (IDLE, RUN) and weight state enum (WIDLE, WLOAD0, WLOAD1);
  - localparams for the k indices of feed and capture (0..4) and for the bit-slice positions in `a_data`/`b_data`.
- One sub-module, `weight_bank_ctrl`, contains:
  - the loader FSM;
  - the B registers;
  - the `shadow_full`/`active_valid` flags;
  - `sel_w_active`/`sel_w_load`, with a swap-request input.
- The top level contains the compute FSM, the A feed and the result capture.

## Test plan
- Reset then idle: `a_ready`=0, `b_ready`=1, `arr_clear_psum`=1, `arr_sel_w_load`=1, all other outputs 0.
- B={1,2;3,4}, then A={1,1;1,1}: row 0 at H+5 is (4,6); row 1 at H+6 is (4,6); `arr_sel_w_active`=1 from H+1.
- Double buffering: load B={1,2;3,4} and start A={2,0;0,3}. During RUN, load B={1,0;0,1}, with loads visible at L+1/L+2. Expected results:
  - job 1 gives (2,4) and (9,12);
  - A={5,6;7,8} then swaps the bank and gives (5,6) and (7,8).
- Maximum values: A and B all 15 gives results (450,450) twice, with no truncation.
- Simultaneous B and A handshake: the A job uses the old bank (no toggle). The next A job toggles and uses the new B.
- `rst_n` low at k2: `res_valid` is never asserted and all outputs return to their reset values. After release, `a_ready`=0 until a new B load completes.
